// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for a five-stage core.
// Resolves, in fixed priority, data-memory wait (freeze), control redirect
// (branch/jump flush) and load-use (one-bubble stall) hazards.
//
// Ports
//   clkCtrl, rst                  : rising-edge clock, async active-high reset
//   IDEX_MemRead, IDEX_rt         : load in ID/EX and its destination register
//   IFID_rs, IFID_rt              : sources of the instruction in IF/ID
//   EXMEM_Branch/ZF/jump          : control transfer resolved in EX/MEM
//   EXMEM_MemRead/MemWrite        : data memory access in EX/MEM
//   mem_ready                     : data memory completes the access this cycle
//   PCWrite..EXMEMWrite           : stage enables (combinational)
//   IFID/IDEX/EXMEM_flush         : zero the target register's controls
//   MEMWB_bubble                  : insert a bubble into MEM/WB
//   pc_sel                        : 0 = PC+4, 1 = branch target, 2 = jump address
//   state                         : FSM state (registered)
//   stall_cnt, flush_cnt          : saturating event counters (registered)
//   mem_timeout                   : sticky memory-timeout flag (registered)
module hazard_ctrl (
  input  logic        clkCtrl,
  input  logic        rst,
  input  logic        IDEX_MemRead,
  input  logic [4:0]  IDEX_rt,
  input  logic [4:0]  IFID_rs,
  input  logic [4:0]  IFID_rt,
  input  logic        EXMEM_Branch,
  input  logic        EXMEM_ZF,
  input  logic        EXMEM_jump,
  input  logic        EXMEM_MemRead,
  input  logic        EXMEM_MemWrite,
  input  logic        mem_ready,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IDEXWrite,
  output logic        EXMEMWrite,
  output logic        IFID_flush,
  output logic        IDEX_flush,
  output logic        EXMEM_flush,
  output logic        MEMWB_bubble,
  output logic [1:0]  pc_sel,
  output logic [1:0]  state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic        mem_timeout
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StStallLu = 2'd1,
    StFlush   = 2'd2,
    StMemWait = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        mem_timeout_q, mem_timeout_d;

  logic mem_busy, redirect, loaduse;
  logic act_mem, act_redir, act_lu;

  always_comb begin
    mem_busy = (EXMEM_MemRead | EXMEM_MemWrite) & ~mem_ready;
    redirect = (EXMEM_Branch & EXMEM_ZF) | EXMEM_jump;
    loaduse  = IDEX_MemRead & (IDEX_rt != 5'd0) &
               ((IDEX_rt == IFID_rs) | (IDEX_rt == IFID_rt));

    // Same priority in every state; the stalled load-use pair is ignored for
    // one cycle so exactly one bubble goes in.
    act_mem   = mem_busy;
    act_redir = redirect & ~mem_busy;
    act_lu    = loaduse & ~mem_busy & ~redirect & (state_q != StStallLu);
  end

  // Combinational controls, forced inactive while reset is asserted.
  always_comb begin
    PCWrite      = 1'b1;
    IFIDWrite    = 1'b1;
    IDEXWrite    = 1'b1;
    EXMEMWrite   = 1'b1;
    IFID_flush   = 1'b0;
    IDEX_flush   = 1'b0;
    EXMEM_flush  = 1'b0;
    MEMWB_bubble = 1'b0;
    pc_sel       = 2'd0;
    state_d      = StRun;

    if (act_mem) begin
      PCWrite      = 1'b0;
      IFIDWrite    = 1'b0;
      IDEXWrite    = 1'b0;
      EXMEMWrite   = 1'b0;
      MEMWB_bubble = 1'b1;
      state_d      = StMemWait;
    end else if (act_redir) begin
      pc_sel      = EXMEM_jump ? 2'd2 : 2'd1;
      IFID_flush  = 1'b1;
      IDEX_flush  = 1'b1;
      EXMEM_flush = 1'b1;
      state_d     = StFlush;
    end else if (act_lu) begin
      PCWrite    = 1'b0;
      IFIDWrite  = 1'b0;
      IDEX_flush = 1'b1;
      state_d    = StStallLu;
    end

    if (rst) begin
      PCWrite      = 1'b0;
      IFIDWrite    = 1'b0;
      IDEXWrite    = 1'b0;
      EXMEMWrite   = 1'b0;
      IFID_flush   = 1'b0;
      IDEX_flush   = 1'b0;
      EXMEM_flush  = 1'b0;
      MEMWB_bubble = 1'b0;
      pc_sel       = 2'd0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if ((act_mem | act_lu) && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end

    flush_cnt_d = flush_cnt_q;
    if (act_redir && (flush_cnt_q != 16'hFFFF)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end

    // Counts only while frozen inside MEMWAIT; any exit (or never entering)
    // leaves it at zero.
    wait_cnt_d    = 4'd0;
    mem_timeout_d = mem_timeout_q;
    if ((state_q == StMemWait) && mem_busy) begin
      wait_cnt_d = (wait_cnt_q == 4'd15) ? 4'd15 : wait_cnt_q + 4'd1;
      if (wait_cnt_d == 4'd15) begin
        mem_timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clkCtrl or posedge rst) begin
    if (rst) begin
      state_q       <= StRun;
      stall_cnt_q   <= 16'd0;
      flush_cnt_q   <= 16'd0;
      wait_cnt_q    <= 4'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign state       = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = mem_timeout_q;

endmodule
